// File: rtl/pipe_pkg.sv
// Shared types for the ID/EXE pipeline boundary: ALU command encoding,
// the staged field bundle and its bubble constant.
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        EXE_NOP  = 4'h0,
        EXE_ADD  = 4'h1,
        EXE_SUB  = 4'h2,
        EXE_AND  = 4'h3,
        EXE_OR   = 4'h4,
        EXE_XOR  = 4'h5,
        EXE_NOR  = 4'h6,
        EXE_SLL  = 4'h7,
        EXE_SRL  = 4'h8,
        EXE_SRA  = 4'h9,
        EXE_SLT  = 4'hA,
        EXE_SLTU = 4'hB,
        EXE_MOV  = 4'hC,
        EXE_LUI  = 4'hD,
        EXE_CMP  = 4'hE,
        EXE_PASS = 4'hF
    } exe_cmd_t;

    typedef struct packed {
        logic                   valid;
        logic [PIPE_DATA_W-1:0] pc;
        logic [4:0]             src1;
        logic [4:0]             src2;
        logic [4:0]             st_src;
        logic [4:0]             dest;
        logic                   wb_en;
        logic                   mem_r_en;
        logic                   mem_w_en;
        exe_cmd_t               exe_cmd;
        logic [PIPE_DATA_W-1:0] val1;
        logic [PIPE_DATA_W-1:0] val2;
        logic [PIPE_DATA_W-1:0] st_val;
        logic [PIPE_DATA_W-1:0] imm;
    } id_exe_t;

    // A bubble has WB_EN clear, so the forwarding unit never matches it.
    localparam id_exe_t BUBBLE = '0;

endpackage

// File: rtl/id_exe_stage_if.sv
// ID/EXE boundary bundle: decoded fields from ID, staged fields to EXE,
// plus flush/hold control, stall and performance counters.
interface id_exe_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = 16
);
    logic              valid_ID;
    logic [DATA_W-1:0] pc_ID;
    logic [4:0]        src1_ID, src2_ID, ST_src_ID;
    logic              src1_used_ID, src2_used_ID;
    logic [4:0]        dest_ID;
    logic              WB_EN_ID, MEM_R_EN_ID, MEM_W_EN_ID;
    logic [3:0]        EXE_CMD_ID;
    logic [DATA_W-1:0] val1_ID, val2_ID, ST_val_ID, imm_ID;
    logic              branch_taken_EXE;
    logic              mem_hold;

    logic              valid_EXE;
    logic [DATA_W-1:0] pc_EXE;
    logic [4:0]        src1_EXE, src2_EXE, ST_src_EXE;
    logic [4:0]        dest_EXE;
    logic              WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE;
    logic [3:0]        EXE_CMD_EXE;
    logic [DATA_W-1:0] val1_EXE, val2_EXE, ST_val_EXE, imm_EXE;
    logic              stall_ID;
    logic [CNT_W-1:0]  bubble_cnt, hold_cnt;

    modport master (
        output valid_ID, pc_ID, src1_ID, src2_ID, ST_src_ID, src1_used_ID, src2_used_ID,
               dest_ID, WB_EN_ID, MEM_R_EN_ID, MEM_W_EN_ID, EXE_CMD_ID,
               val1_ID, val2_ID, ST_val_ID, imm_ID, branch_taken_EXE, mem_hold,
        input  valid_EXE, pc_EXE, src1_EXE, src2_EXE, ST_src_EXE, dest_EXE,
               WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, EXE_CMD_EXE,
               val1_EXE, val2_EXE, ST_val_EXE, imm_EXE, stall_ID, bubble_cnt, hold_cnt
    );

    modport slave (
        input  valid_ID, pc_ID, src1_ID, src2_ID, ST_src_ID, src1_used_ID, src2_used_ID,
               dest_ID, WB_EN_ID, MEM_R_EN_ID, MEM_W_EN_ID, EXE_CMD_ID,
               val1_ID, val2_ID, ST_val_ID, imm_ID, branch_taken_EXE, mem_hold,
        output valid_EXE, pc_EXE, src1_EXE, src2_EXE, ST_src_EXE, dest_EXE,
               WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, EXE_CMD_EXE,
               val1_EXE, val2_EXE, ST_val_EXE, imm_EXE, stall_ID, bubble_cnt, hold_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard: the instruction in ID reads a register that the load
// currently in EXE has not produced yet.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_src1,
    input  logic       id_src1_used,
    input  logic [4:0] id_src2,
    input  logic       id_src2_used,
    input  logic [4:0] id_st_src,
    input  logic       id_mem_w_en,
    input  logic       exe_valid,
    input  logic       exe_mem_r_en,
    input  logic [4:0] exe_dest,
    output logic       lu_hazard
);
    logic load_in_exe;
    logic src_match;

    assign load_in_exe = exe_valid && exe_mem_r_en && (exe_dest != REG_ZERO);

    assign src_match = (id_src1_used && (id_src1 == exe_dest))
                    || (id_src2_used && (id_src2 == exe_dest))
                    || (id_mem_w_en  && (id_st_src == exe_dest));

    assign lu_hazard = load_in_exe && src_match && id_valid;

endmodule

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with load-use bubble insertion, branch flush,
// memory hold and saturating bubble/hold counters.
module id_exe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = 16
) (
    input logic     clk,
    input logic     rst,
    id_exe_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    id_exe_t          stage_q;
    id_exe_t          id_fields;
    logic             lu_hazard;
    logic [CNT_W-1:0] bubble_q;
    logic [CNT_W-1:0] hold_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    endfunction

    hazard_detect u_hazard (
        .id_valid     (bus.valid_ID),
        .id_src1      (bus.src1_ID),
        .id_src1_used (bus.src1_used_ID),
        .id_src2      (bus.src2_ID),
        .id_src2_used (bus.src2_used_ID),
        .id_st_src    (bus.ST_src_ID),
        .id_mem_w_en  (bus.MEM_W_EN_ID),
        .exe_valid    (stage_q.valid),
        .exe_mem_r_en (stage_q.mem_r_en),
        .exe_dest     (stage_q.dest),
        .lu_hazard    (lu_hazard)
    );

    always_comb begin
        id_fields          = BUBBLE;
        id_fields.valid    = bus.valid_ID;
        id_fields.pc       = PIPE_DATA_W'(bus.pc_ID);
        id_fields.src1     = bus.src1_ID;
        id_fields.src2     = bus.src2_ID;
        id_fields.st_src   = bus.ST_src_ID;
        id_fields.dest     = bus.dest_ID;
        id_fields.exe_cmd  = exe_cmd_t'(bus.EXE_CMD_ID);
        id_fields.val1     = PIPE_DATA_W'(bus.val1_ID);
        id_fields.val2     = PIPE_DATA_W'(bus.val2_ID);
        id_fields.st_val   = PIPE_DATA_W'(bus.ST_val_ID);
        id_fields.imm      = PIPE_DATA_W'(bus.imm_ID);
        // An empty ID slot must not write back or touch memory downstream.
        id_fields.wb_en    = bus.valid_ID && bus.WB_EN_ID;
        id_fields.mem_r_en = bus.valid_ID && bus.MEM_R_EN_ID;
        id_fields.mem_w_en = bus.valid_ID && bus.MEM_W_EN_ID;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q  <= BUBBLE;
            bubble_q <= '0;
            hold_q   <= '0;
        end else if (bus.branch_taken_EXE) begin
            stage_q  <= BUBBLE;
        end else if (bus.mem_hold) begin
            hold_q   <= sat_inc(hold_q);
        end else if (lu_hazard) begin
            stage_q  <= BUBBLE;
            bubble_q <= sat_inc(bubble_q);
        end else begin
            stage_q  <= id_fields;
        end
    end

    assign bus.stall_ID     = !bus.branch_taken_EXE && (bus.mem_hold || lu_hazard);

    assign bus.valid_EXE    = stage_q.valid;
    assign bus.pc_EXE       = DATA_W'(stage_q.pc);
    assign bus.src1_EXE     = stage_q.src1;
    assign bus.src2_EXE     = stage_q.src2;
    assign bus.ST_src_EXE   = stage_q.st_src;
    assign bus.dest_EXE     = stage_q.dest;
    assign bus.WB_EN_EXE    = stage_q.wb_en;
    assign bus.MEM_R_EN_EXE = stage_q.mem_r_en;
    assign bus.MEM_W_EN_EXE = stage_q.mem_w_en;
    assign bus.EXE_CMD_EXE  = stage_q.exe_cmd;
    assign bus.val1_EXE     = DATA_W'(stage_q.val1);
    assign bus.val2_EXE     = DATA_W'(stage_q.val2);
    assign bus.ST_val_EXE   = DATA_W'(stage_q.st_val);
    assign bus.imm_EXE      = DATA_W'(stage_q.imm);
    assign bus.bubble_cnt   = bubble_q;
    assign bus.hold_cnt     = hold_q;

endmodule

// File: tb/tb_id_exe_stage.sv
// Bench for id_exe_stage: directed hazard/flush/hold/saturation scenarios
// followed by randomized traffic, all compared against a cycle-level model.
module tb_id_exe_stage;

    localparam int DW      = 32;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    id_exe_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    id_exe_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  src1, src2, st_src, dest;
        logic        wb, mr, mw;
        logic [3:0]  cmd;
        logic [31:0] v1, v2, sv, imm;
    } exe_t;

    exe_t m;
    int   m_bub;
    int   m_hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exe_t empty_slot();
        exe_t e = '{default: 0};
        return e;
    endfunction

    function automatic exe_t from_id();
        exe_t e;
        e.valid  = bus.valid_ID;
        e.pc     = bus.pc_ID;
        e.src1   = bus.src1_ID;
        e.src2   = bus.src2_ID;
        e.st_src = bus.ST_src_ID;
        e.dest   = bus.dest_ID;
        e.wb     = bus.valid_ID ? bus.WB_EN_ID    : 1'b0;
        e.mr     = bus.valid_ID ? bus.MEM_R_EN_ID : 1'b0;
        e.mw     = bus.valid_ID ? bus.MEM_W_EN_ID : 1'b0;
        e.cmd    = bus.EXE_CMD_ID;
        e.v1     = bus.val1_ID;
        e.v2     = bus.val2_ID;
        e.sv     = bus.ST_val_ID;
        e.imm    = bus.imm_ID;
        return e;
    endfunction

    function automatic bit model_lu();
        bit reads;
        reads = (bus.src1_used_ID && bus.src1_ID == m.dest)
             || (bus.src2_used_ID && bus.src2_ID == m.dest)
             || (bus.MEM_W_EN_ID && bus.ST_src_ID == m.dest);
        return m.valid && m.mr && (m.dest != 0) && bus.valid_ID && reads;
    endfunction

    task automatic check_all();
        bit exp_stall;
        exp_stall = !bus.branch_taken_EXE && (bus.mem_hold || model_lu());
        chk("stall_ID",   32'(bus.stall_ID),     32'(exp_stall));
        chk("valid_EXE",  32'(bus.valid_EXE),    32'(m.valid));
        chk("pc_EXE",     bus.pc_EXE,            m.pc);
        chk("src1_EXE",   32'(bus.src1_EXE),     32'(m.src1));
        chk("src2_EXE",   32'(bus.src2_EXE),     32'(m.src2));
        chk("st_src_EXE", 32'(bus.ST_src_EXE),   32'(m.st_src));
        chk("dest_EXE",   32'(bus.dest_EXE),     32'(m.dest));
        chk("wb_EXE",     32'(bus.WB_EN_EXE),    32'(m.wb));
        chk("mr_EXE",     32'(bus.MEM_R_EN_EXE), 32'(m.mr));
        chk("mw_EXE",     32'(bus.MEM_W_EN_EXE), 32'(m.mw));
        chk("cmd_EXE",    32'(bus.EXE_CMD_EXE),  32'(m.cmd));
        chk("val1_EXE",   bus.val1_EXE,          m.v1);
        chk("val2_EXE",   bus.val2_EXE,          m.v2);
        chk("st_val_EXE", bus.ST_val_EXE,        m.sv);
        chk("imm_EXE",    bus.imm_EXE,           m.imm);
        chk("bubble_cnt", 32'(bus.bubble_cnt),   32'(m_bub));
        chk("hold_cnt",   32'(bus.hold_cnt),     32'(m_hold));
    endtask

    // Check outputs mid-cycle, then advance the model across the next rising edge.
    task automatic tick();
        exe_t nxt;
        int   nb;
        int   nh;
        @(negedge clk);
        check_all();
        nxt = m;
        nb  = m_bub;
        nh  = m_hold;
        if (rst) begin
            nxt = empty_slot();
            nb  = 0;
            nh  = 0;
        end else if (bus.branch_taken_EXE) begin
            nxt = empty_slot();
        end else if (bus.mem_hold) begin
            nh = (m_hold < CNT_MAX) ? m_hold + 1 : m_hold;
        end else if (model_lu()) begin
            nxt = empty_slot();
            nb  = (m_bub < CNT_MAX) ? m_bub + 1 : m_bub;
        end else begin
            nxt = from_id();
        end
        @(posedge clk);
        #1;
        m      = nxt;
        m_bub  = nb;
        m_hold = nh;
    endtask

    task automatic set_id(input bit valid, input int dest, input int s1, input bit s1u,
                          input int s2, input bit s2u, input int st,
                          input bit wb, input bit mr, input bit mw, input int cmd);
        bus.valid_ID     = valid;
        bus.pc_ID        = $urandom;
        bus.dest_ID      = 5'(dest);
        bus.src1_ID      = 5'(s1);
        bus.src1_used_ID = s1u;
        bus.src2_ID      = 5'(s2);
        bus.src2_used_ID = s2u;
        bus.ST_src_ID    = 5'(st);
        bus.WB_EN_ID     = wb;
        bus.MEM_R_EN_ID  = mr;
        bus.MEM_W_EN_ID  = mw;
        bus.EXE_CMD_ID   = 4'(cmd);
        bus.val1_ID      = $urandom;
        bus.val2_ID      = $urandom;
        bus.ST_val_ID    = $urandom;
        bus.imm_ID       = $urandom;
    endtask

    task automatic rand_inputs();
        bit mr;
        mr = ($urandom_range(0, 2) == 0);
        set_id($urandom_range(0, 9) != 0, $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               mr, !mr && ($urandom_range(0, 3) == 0), $urandom_range(0, 15));
        bus.branch_taken_EXE = ($urandom_range(0, 9) == 0);
        bus.mem_hold         = ($urandom_range(0, 6) == 0);
        rst                  = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        m      = empty_slot();
        m_bub  = 0;
        m_hold = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.branch_taken_EXE = 1'b0;
        bus.mem_hold         = 1'b0;

        // Reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(bus.valid_EXE), 32'd0);
        chk("rst_bub", 32'(bus.bubble_cnt), 32'd0);
        chk("rst_hold", 32'(bus.hold_cnt), 32'd0);

        // Plain flow
        set_id(1, 5, 1, 1, 2, 1, 0, 1, 0, 0, 1);
        #1 chk("flow_stall", 32'(bus.stall_ID), 32'd0);
        tick();
        chk("flow_dest", 32'(bus.dest_EXE), 32'd5);
        chk("flow_cmd", 32'(bus.EXE_CMD_EXE), 32'd1);
        chk("flow_valid", 32'(bus.valid_EXE), 32'd1);
        chk("flow_bub", 32'(bus.bubble_cnt), 32'd0);

        // Load-use: load r3 then dependent add
        set_id(1, 3, 1, 1, 2, 1, 0, 1, 1, 0, 1);
        tick();
        set_id(1, 6, 3, 1, 0, 0, 0, 1, 0, 0, 1);
        #1 chk("lu_stall", 32'(bus.stall_ID), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(bus.valid_EXE), 32'd0);
        chk("lu_bubble_wb", 32'(bus.WB_EN_EXE), 32'd0);
        chk("lu_bub_cnt", 32'(bus.bubble_cnt), 32'd1);
        chk("lu_stall_drop", 32'(bus.stall_ID), 32'd0);
        tick();
        chk("lu_add_valid", 32'(bus.valid_EXE), 32'd1);
        chk("lu_add_src1", 32'(bus.src1_EXE), 32'd3);

        // Zero destination, unused operand, store source
        set_id(1, 0, 1, 1, 2, 1, 0, 1, 1, 0, 1);
        tick();
        set_id(1, 7, 0, 1, 0, 1, 0, 1, 0, 0, 1);
        #1 chk("r0_stall", 32'(bus.stall_ID), 32'd0);
        set_id(1, 4, 1, 1, 2, 1, 0, 1, 1, 0, 1);
        tick();
        set_id(1, 8, 1, 1, 4, 0, 0, 1, 0, 0, 1);
        #1 chk("unused_stall", 32'(bus.stall_ID), 32'd0);
        set_id(1, 0, 1, 1, 2, 1, 4, 0, 0, 1, 1);
        #1 chk("store_stall", 32'(bus.stall_ID), 32'd1);
        tick();
        chk("store_bub_cnt", 32'(bus.bubble_cnt), 32'd2);

        // Flush beats hold and load-use
        set_id(1, 3, 1, 1, 2, 1, 0, 1, 1, 0, 1);
        tick();
        set_id(1, 6, 3, 1, 0, 0, 0, 1, 0, 0, 1);
        bus.mem_hold         = 1'b1;
        bus.branch_taken_EXE = 1'b1;
        #1 chk("flush_stall", 32'(bus.stall_ID), 32'd0);
        tick();
        bus.mem_hold         = 1'b0;
        bus.branch_taken_EXE = 1'b0;
        chk("flush_valid", 32'(bus.valid_EXE), 32'd0);
        chk("flush_bub", 32'(bus.bubble_cnt), 32'd2);
        chk("flush_hold", 32'(bus.hold_cnt), 32'd0);

        // Memory hold for three cycles
        set_id(1, 7, 1, 1, 2, 1, 0, 1, 0, 0, 2);
        tick();
        set_id(1, 9, 1, 1, 2, 1, 0, 1, 0, 0, 3);
        bus.mem_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_stall", 32'(bus.stall_ID), 32'd1);
            tick();
            chk("hold_dest", 32'(bus.dest_EXE), 32'd7);
        end
        bus.mem_hold = 1'b0;
        chk("hold_cnt3", 32'(bus.hold_cnt), 32'd3);

        // Bubble counter saturation
        for (int i = 0; i < 3; i++) begin
            set_id(1, 2, 1, 1, 1, 1, 0, 1, 1, 0, 1);
            tick();
            set_id(1, 5, 2, 1, 0, 0, 0, 1, 0, 0, 1);
            tick();
        end
        chk("sat_bub", 32'(bus.bubble_cnt), 32'd3);

        // Reset during hold
        set_id(1, 9, 1, 1, 2, 1, 0, 1, 1, 0, 4);
        tick();
        bus.mem_hold = 1'b1;
        rst          = 1'b1;
        tick();
        rst          = 1'b0;
        bus.mem_hold = 1'b0;
        chk("rsthold_valid", 32'(bus.valid_EXE), 32'd0);
        chk("rsthold_dest", 32'(bus.dest_EXE), 32'd0);
        chk("rsthold_bub", 32'(bus.bubble_cnt), 32'd0);
        chk("rsthold_hold", 32'(bus.hold_cnt), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rand_inputs();
            tick();
        end
        rst = 1'b0;
        bus.branch_taken_EXE = 1'b0;
        bus.mem_hold = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_exe_stage.md
# id_exe_stage

Pipeline register and load-use hazard controller between the ID and EXE stages of the 5-stage core. It captures decoded operands and control from ID and presents the registered `*_EXE` fields to the EXE stage and the forwarding unit, which consumes `src1_EXE`, `src2_EXE` and `ST_src_EXE`. It detects load-use hazards against the instruction currently in EXE and inserts a one-cycle bubble. It also honours branch flush and memory hold, and keeps saturating stall and bubble performance counters.

## Interface
- DATA_W, 32, operand/PC/immediate width
- CNT_W, 16, performance counter width
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- valid_ID  input  1  ID holds a real instruction
- pc_ID  input  DATA_W  instruction PC
- src1_ID, src2_ID, ST_src_ID  input  5 each  source register indices
- src1_used_ID, src2_used_ID  input  1 each  operand actually read from the register file
- dest_ID  input  5  destination register
- WB_EN_ID, MEM_R_EN_ID, MEM_W_EN_ID  input  1 each  control bits
- EXE_CMD_ID  input  4  ALU command
- val1_ID, val2_ID, ST_val_ID, imm_ID  input  DATA_W each  register-file values and immediate
- branch_taken_EXE  input  1  branch resolved taken in EXE; flush
- mem_hold  input  1  data memory busy; freeze the pipeline
- valid_EXE, pc_EXE, src1_EXE, src2_EXE, ST_src_EXE, dest_EXE, WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, EXE_CMD_EXE, val1_EXE, val2_EXE, ST_val_EXE, imm_EXE  output  as matching *_ID  registered fields
- stall_ID  output  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt, hold_cnt  output  CNT_W each  saturating event counters

## Operation
- Load-use hazard (`lu_hazard`) is asserted when all of the following hold:
  - valid_EXE and MEM_R_EN_EXE;
  - dest_EXE != 0;
  - at least one of: (src1_used_ID and src1_ID == dest_EXE), (src2_used_ID and src2_ID == dest_EXE), (MEM_W_EN_ID and ST_src_ID == dest_EXE);
  - valid_ID.
- Per-cycle update priority, highest first:
  1. rst: all outputs cleared to 0, counters cleared.
  2. branch_taken_EXE: register loads a bubble (valid_EXE=0, WB_EN/MEM_R_EN/MEM_W_EN=0, all other fields 0). Flush wins over mem_hold.
  3. mem_hold: register holds its value. hold_cnt increments.
  4. lu_hazard: register loads a bubble. bubble_cnt increments.
  5. otherwise: register loads all *_ID fields. When valid_ID=0, control bits are forced to 0.
- stall_ID = !branch_taken_EXE & (mem_hold | lu_hazard).
- A bubble always has WB_EN_EXE=0, so it never triggers forwarding.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- No explicit FSM. The registered valid_EXE/MEM_R_EN_EXE pair forms the implicit state: RUN, LOAD_IN_EXE, BUBBLE.
  - A load in EXE with a dependent instruction in ID gives exactly one bubble. The next cycle the load is in MEM, lu_hazard drops, and forwarding covers the dependency.
- Back-to-back loads, each dependent on the previous: one bubble per pair, no deadlock.

## Timing
- Latency is one cycle from *_ID to *_EXE.
- stall_ID is a combinational function of the current inputs and register state, asserted in the same cycle the hazard is present.
- mem_hold and a load-use hazard together: hold takes effect. lu_hazard re-evaluates after the hold is released, still inserts exactly one bubble, and bubble_cnt is not incremented during hold cycles.
- rst asserted mid-stall: next cycle all outputs are 0 and stall_ID depends only on the current inputs (lu_hazard cannot fire while valid_EXE=0).
- Reset values: every output 0, including bubble_cnt and hold_cnt.

## Structure
- Shared package `pipe_pkg`:
  - `exe_cmd_t` (4-bit enum);
  - `id_exe_t` packed struct holding all staged fields;
  - `REG_ZERO` = 5'd0;
  - `BUBBLE` constant of type `id_exe_t`.
- Sub-module `hazard_detect`: purely combinational; computes lu_hazard from the ID sources and the EXE load/destination.
- The register and counters live in `id_exe_stage`.

## Test plan
- Plain flow, no hazards: ID instruction with dest=5, EXE_CMD=4'h1 → appears on *_EXE next cycle; stall_ID=0; counters stay 0.
- Load-use hazard: load to r3 in EXE, ID add with src1=3 (src1_used=1) → stall_ID=1 for one cycle; valid_EXE=0 next cycle; bubble_cnt=1; the add enters EXE one cycle later.
- Zero destination and unused operands:
  - load to r0 with ID src1=0 → no stall;
  - load to r4 with ID src2=4 but src2_used=0 → no stall;
  - store with ST_src=4 → stall.
- Flush versus hold: branch_taken_EXE=1 together with mem_hold=1 and lu_hazard=1 → next cycle valid_EXE=0; stall_ID=0; no counter changes.
- Memory hold: mem_hold high for 3 cycles → *_EXE unchanged and stall_ID=1 throughout; hold_cnt=3.
- Saturation and reset:
  - with CNT_W=2, force 5 bubbles → bubble_cnt=3;
  - assert rst during a hold → all outputs 0 the next cycle.
